tt_um_jleugeri_ttt_scheduler: RTL and testbench
===============================================

TT_UM_JLEUGERI_TTT_SCHEDULER -- requirements
Module: tt_um_jleugeri_ttt_scheduler

Interface
REQ-001 SHALL have parameter NUM_PROCESSORS, default 10, number of processors scanned per round (>=2).
REQ-002 SHALL have parameter IDX_W, default $clog2(NUM_PROCESSORS), processor index width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port go_in  input  1  round start request, sampled only in IDLE.
REQ-006 SHALL have port tstartstop_in  input  2*NUM_PROCESSORS  bit 2i = start event, bit 2i+1 = stop event of processor i.
REQ-007 SHALL have port next_in  input  1  downstream accept of the current event.
REQ-008 SHALL have port valid_out  output  1  idx_out/t_start_out/t_stop_out hold a pending event.
REQ-009 SHALL have port idx_out  output  IDX_W  index of the emitted processor.
REQ-010 SHALL have port t_start_out  output  1  start flag of the emitted processor.
REQ-011 SHALL have port t_stop_out  output  1  stop flag of the emitted processor.
REQ-012 SHALL have port hot_out  output  1  round in progress (SCAN or EMIT).
REQ-013 SHALL have port done_out  output  1  one-cycle round-complete pulse.
REQ-014 SHALL have port event_count_out  output  IDX_W+1  events accepted in the last or current round.

Function
REQ-015 SHALL implement states IDLE, SCAN, EMIT, DONE; all outputs registered or decoded from registered state only.
REQ-016 SHALL, in IDLE with go_in=1, snapshot tstartstop_in, clear idx and event_count_out, and enter SCAN next cycle.
REQ-017 SHALL ignore go_in in SCAN, EMIT and DONE; tstartstop_in changes after the snapshot SHALL NOT affect the round.
REQ-018 SHALL, in SCAN, enter EMIT if snapshot pair at idx is nonzero; otherwise increment idx, or enter DONE if idx = NUM_PROCESSORS-1.
REQ-019 SHALL, in EMIT, assert valid_out with idx_out/t_start_out/t_stop_out stable until next_in=1.
REQ-020 SHALL, on EMIT with next_in=1, clear that snapshot pair, increment event_count_out, then enter SCAN at idx+1, or DONE if idx = NUM_PROCESSORS-1.
REQ-021 SHALL emit start=1 and stop=1 together as a single event when both snapshot bits are set.
REQ-022 SHALL ignore next_in outside EMIT.
REQ-023 SHALL assert done_out for exactly the one DONE cycle, then return to IDLE; hot_out=0 in IDLE and DONE.
REQ-024 SHALL hold event_count_out from DONE until the next accepted go_in.
REQ-025 SHALL drive valid_out, t_start_out, t_stop_out to 0 and hold idx_out at its last value outside EMIT.

Reset
REQ-026 SHALL, on rst_n=0, immediately enter IDLE and clear snapshot, idx, event_count_out, valid_out, t_start_out, t_stop_out, hot_out and done_out, including mid-round.
REQ-027 SHALL NOT emit done_out for a round aborted by reset.

Configuration
REQ-028 SHALL, with TTT_SCHED_FASTSKIP_EN defined, make SCAN priority-encode the lowest pending snapshot index in one cycle, entering EMIT at it or DONE if none pend.
REQ-029 SHALL, without TTT_SCHED_FASTSKIP_EN, step SCAN one index per cycle per REQ-018; emitted event order and values SHALL be identical in both builds.

Verification
REQ-030 SHALL cover: N=10, events start@3, stop@7, next_in=1, no macro, go at cycle 0 -> EMIT idx 3 at cycle 5, idx 7 at cycle 10, done_out at cycle 13, event_count_out=2.
REQ-031 SHALL cover: same stimulus with TTT_SCHED_FASTSKIP_EN -> EMIT idx 3 at cycle 2, idx 7 at cycle 4, done_out at cycle 6.
REQ-032 SHALL cover: empty snapshot -> no valid_out, done_out at cycle 11 (no macro) or cycle 2 (macro), event_count_out=0.
REQ-033 SHALL cover: processor 9 both bits set, next_in held 0 for 5 cycles -> valid_out, idx_out=9, start=stop=1 held stable 6 cycles, then DONE.
REQ-034 SHALL cover: tstartstop_in toggled and go_in re-pulsed mid-round -> emitted events match the initial snapshot, single done_out.
REQ-035 SHALL cover: rst_n low during EMIT -> all outputs 0 asynchronously, no done_out, next go_in starts a clean round.

Source files
------------

// File: rtl/tt_um_jleugeri_ttt_scheduler.sv
// Round-based event scheduler: snapshots per-processor start/stop flags and emits them in index order.
// Optional build macro TTT_SCHED_FASTSKIP_EN replaces the one-index-per-cycle scan with a priority encoder.
module tt_um_jleugeri_ttt_scheduler #(
  parameter int NUM_PROCESSORS = 10,
  parameter int IDX_W          = $clog2(NUM_PROCESSORS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        go_in,
  input  logic [2*NUM_PROCESSORS-1:0] tstartstop_in,
  input  logic                        next_in,
  output logic                        valid_out,
  output logic [IDX_W-1:0]            idx_out,
  output logic                        t_start_out,
  output logic                        t_stop_out,
  output logic                        hot_out,
  output logic                        done_out,
  output logic [IDX_W:0]              event_count_out
);

  typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PROCESSORS - 1);

`ifdef TTT_SCHED_FASTSKIP_EN
  localparam bit FASTSKIP = 1'b1;
`else
  localparam bit FASTSKIP = 1'b0;
`endif

  state_t                           state, state_nxt;
  logic [NUM_PROCESSORS-1:0][1:0]   snap;      // [i][0] = start, [i][1] = stop
  logic [IDX_W-1:0]                 idx;
  logic [IDX_W-1:0]                 idx_q;
  logic [IDX_W:0]                   count;
  logic                             hit;
  logic [IDX_W-1:0]                 emit_idx;

`ifdef TTT_SCHED_FASTSKIP_EN
  // Cleared pairs below idx never re-arm, so the lowest pending index is always >= idx.
  always_comb begin
    hit      = 1'b0;
    emit_idx = '0;
    for (int i = NUM_PROCESSORS - 1; i >= 0; i--) begin
      if (snap[i] != 2'b00) begin
        hit      = 1'b1;
        emit_idx = IDX_W'(i);
      end
    end
  end
`else
  assign hit      = |snap[idx];
  assign emit_idx = idx;
`endif

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (go_in) state_nxt = SCAN;
      SCAN: begin
        if (hit)                             state_nxt = EMIT;
        else if (FASTSKIP || idx == LAST_IDX) state_nxt = DONE;
      end
      EMIT: if (next_in) state_nxt = (idx == LAST_IDX) ? DONE : SCAN;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; the snapshot is
  // deliberately reset too, so an aborted round leaves no stale events behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      snap  <= '0;
      idx   <= '0;
      idx_q <= '0;
      count <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (go_in) begin
            snap  <= tstartstop_in;
            idx   <= '0;
            count <= '0;
          end
        end
        SCAN: begin
          if (hit) begin
            idx   <= emit_idx;
            idx_q <= emit_idx;
          end else if (!FASTSKIP && idx != LAST_IDX) begin
            idx <= idx + 1'b1;
          end
        end
        EMIT: begin
          if (next_in) begin
            snap[idx] <= 2'b00;
            count     <= count + 1'b1;
            if (idx != LAST_IDX) idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode directly from registered state, so reset clears them without waiting for a clock.
  assign valid_out       = (state == EMIT);
  assign t_start_out     = valid_out & snap[idx][0];
  assign t_stop_out      = valid_out & snap[idx][1];
  assign hot_out         = (state == SCAN) || (state == EMIT);
  assign done_out        = (state == DONE);
  assign idx_out         = idx_q;
  assign event_count_out = count;

endmodule

// File: tb/tb_tt_um_jleugeri_ttt_scheduler.sv
// Directed self-checking bench for tt_um_jleugeri_ttt_scheduler (either build of TTT_SCHED_FASTSKIP_EN).
module tb_tt_um_jleugeri_ttt_scheduler;

  localparam int N  = 10;
  localparam int IW = 4;

`ifdef TTT_SCHED_FASTSKIP_EN
  localparam int E1_CYC = 2, E2_CYC = 4, D_CYC = 6, EMPTY_D_CYC = 2, P9_CYC = 2;
`else
  localparam int E1_CYC = 5, E2_CYC = 10, D_CYC = 13, EMPTY_D_CYC = 11, P9_CYC = 11;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            go_in;
  logic [2*N-1:0]  tstartstop_in;
  logic            next_in;
  logic            valid_out;
  logic [IW-1:0]   idx_out;
  logic            t_start_out;
  logic            t_stop_out;
  logic            hot_out;
  logic            done_out;
  logic [IW:0]     event_count_out;

  tt_um_jleugeri_ttt_scheduler #(.NUM_PROCESSORS(N)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .go_in           (go_in),
    .tstartstop_in   (tstartstop_in),
    .next_in         (next_in),
    .valid_out       (valid_out),
    .idx_out         (idx_out),
    .t_start_out     (t_start_out),
    .t_stop_out      (t_stop_out),
    .hot_out         (hot_out),
    .done_out        (done_out),
    .event_count_out (event_count_out)
  );

  always #5 clk = ~clk;

  int passes = 0;
  int total  = 0;

  int          n_emit;
  int          done_cyc;
  int          emit_cyc [4];
  logic [IW-1:0] emit_idx [4];
  logic        emit_st [4];
  logic        emit_sp [4];
  logic [IW:0] done_cnt;

  // Standard stimulus: start event on processor 3, stop event on processor 7.
  localparam logic [2*N-1:0] STD_SNAP = 20'h0_8040;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Pulses go at cycle 0 and logs every emitted event until done_out (bounded).
  task automatic run_round(input logic [2*N-1:0] snap_val, input int poke_cyc,
                           input logic [2*N-1:0] poke_val);
    n_emit   = 0;
    done_cyc = -1;
    done_cnt = '0;
    @(posedge clk); #1;
    tstartstop_in = snap_val;
    go_in         = 1'b1;
    next_in       = 1'b1;
    @(posedge clk); #1;
    go_in = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (c == poke_cyc) begin
        tstartstop_in = poke_val;
        go_in         = 1'b1;
      end else begin
        go_in = 1'b0;
      end
      @(negedge clk);
      if (valid_out && n_emit < 4) begin
        emit_cyc[n_emit] = c;
        emit_idx[n_emit] = idx_out;
        emit_st[n_emit]  = t_start_out;
        emit_sp[n_emit]  = t_stop_out;
        n_emit++;
      end
      if (done_out) begin
        done_cyc = c;
        done_cnt = event_count_out;
        break;
      end
      @(posedge clk); #1;
    end
    go_in = 1'b0;
    check("round_terminates", (done_cyc > 0), 1);
  endtask

  task automatic check_after_done(input string p);
    @(posedge clk); #1;
    @(negedge clk);
    check({p, "_done_one_cycle"}, done_out, 0);
    check({p, "_idle_not_hot"}, hot_out, 0);
    check({p, "_idle_no_valid"}, valid_out, 0);
  endtask

  task automatic check_std_round(input string p);
    check({p, "_n_emit"},   n_emit, 2);
    check({p, "_e0_idx"},   emit_idx[0], 3);
    check({p, "_e0_start"}, emit_st[0], 1);
    check({p, "_e0_stop"},  emit_sp[0], 0);
    check({p, "_e0_cyc"},   emit_cyc[0], E1_CYC);
    check({p, "_e1_idx"},   emit_idx[1], 7);
    check({p, "_e1_start"}, emit_st[1], 0);
    check({p, "_e1_stop"},  emit_sp[1], 1);
    check({p, "_e1_cyc"},   emit_cyc[1], E2_CYC);
    check({p, "_done_cyc"}, done_cyc, D_CYC);
    check({p, "_count"},    done_cnt, 2);
    check_after_done(p);
  endtask

  initial begin
    int found;

    // Reset state
    rst_n         = 1'b0;
    go_in         = 1'b0;
    next_in       = 1'b0;
    tstartstop_in = '0;
    #12;
    check("rst_valid", valid_out, 0);
    check("rst_hot",   hot_out, 0);
    check("rst_done",  done_out, 0);
    check("rst_idx",   idx_out, 0);
    check("rst_count", event_count_out, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Start@3 / stop@7 with next_in always high
    run_round(STD_SNAP, 0, '0);
    check_std_round("std");
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("count_held_idle", event_count_out, 2);
    check("idx_held_idle",   idx_out, 7);

    // Empty snapshot
    run_round('0, 0, '0);
    check("empty_n_emit",   n_emit, 0);
    check("empty_done_cyc", done_cyc, EMPTY_D_CYC);
    check("empty_count",    done_cnt, 0);
    check_after_done("empty");

    // Processor 9 with both flags, downstream stalls 5 cycles
    @(posedge clk); #1;
    tstartstop_in = 20'hC_0000;
    go_in         = 1'b1;
    next_in       = 1'b0;
    @(posedge clk); #1;
    go_in         = 1'b0;
    tstartstop_in = '0;
    found = -1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (valid_out) begin
        found = c;
        break;
      end
      @(posedge clk); #1;
    end
    check("p9_emit_cyc", found, P9_CYC);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        if (k == 5) next_in = 1'b1;
        @(negedge clk);
      end
      check("p9_valid", valid_out, 1);
      check("p9_idx",   idx_out, 9);
      check("p9_start", t_start_out, 1);
      check("p9_stop",  t_stop_out, 1);
      check("p9_done_low", done_out, 0);
    end
    @(posedge clk); #1;
    next_in = 1'b0;
    @(negedge clk);
    check("p9_done",       done_out, 1);
    check("p9_count",      event_count_out, 1);
    check("p9_valid_gone", valid_out, 0);
    check_after_done("p9");

    // Inputs toggled and go re-pulsed mid-round must not disturb the snapshot
    run_round(STD_SNAP, 3, '1);
    tstartstop_in = '0;
    check_std_round("poke");

    // Asynchronous reset while an event is pending
    @(posedge clk); #1;
    tstartstop_in = 20'h0_0040;
    go_in         = 1'b1;
    next_in       = 1'b0;
    @(posedge clk); #1;
    go_in         = 1'b0;
    found = -1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (valid_out) begin
        found = c;
        break;
      end
      @(posedge clk); #1;
    end
    check("rstmid_emit_seen", (found > 0), 1);
    check("rstmid_pre_idx",   idx_out, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_valid", valid_out, 0);
    check("rstmid_start", t_start_out, 0);
    check("rstmid_stop",  t_stop_out, 0);
    check("rstmid_hot",   hot_out, 0);
    check("rstmid_done",  done_out, 0);
    check("rstmid_idx",   idx_out, 0);
    check("rstmid_count", event_count_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("rstmid_no_done", done_out, 0);
      check("rstmid_no_hot",  hot_out, 0);
    end
    run_round(STD_SNAP, 0, '0);
    check_std_round("after_rst");

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
